// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALUOp, funct and opcode values, multiply/divide states.
package ex_pkg;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;
  localparam logic [1:0] AluOpImm   = 2'b11;

  localparam logic [5:0] FnSll   = 6'h00;
  localparam logic [5:0] FnSrl   = 6'h02;
  localparam logic [5:0] FnSra   = 6'h03;
  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnXor   = 6'h26;
  localparam logic [5:0] FnNor   = 6'h27;
  localparam logic [5:0] FnSlt   = 6'h2A;
  localparam logic [5:0] FnSltu  = 6'h2B;

  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

  // mult/multu/div/divu occupy funct 0x18..0x1B; low two bits select the operation.
  function automatic logic is_muldiv_funct(input logic [5:0] funct);
    return funct[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply/divide unit owning HI/LO; signed ops run on magnitudes.
module muldiv_unit
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stall_o
);

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, mag_b_q, mag_b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag;

  assign a_neg    = ~op_i[0] & a_i[31];
  assign b_neg    = ~op_i[0] & b_i[31];
  assign a_mag    = a_neg ? (32'd0 - a_i) : a_i;
  assign b_mag    = b_neg ? (32'd0 - b_i) : b_i;
  assign div_zero = op_i[1] & (b_i == 32'd0);

  logic [32:0] mul_sum, div_shift, div_diff;
  logic        div_fits;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod_fix;

  // acc_hi holds the partial product / remainder, acc_lo the multiplier / quotient.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : 33'd0);
    div_shift = {acc_hi_q, acc_lo_q[31]};
    div_diff  = div_shift - {1'b0, mag_b_q};
    div_fits  = ~div_diff[32];
    if (is_div_q) begin
      step_hi = div_fits ? div_diff[31:0] : div_shift[31:0];
      step_lo = {acc_lo_q[30:0], div_fits};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], acc_lo_q[31:1]};
    end
    prod_fix = neg_res_q ? (64'd0 - {step_hi, step_lo}) : {step_hi, step_lo};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    mag_b_d   = mag_b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (div_zero) begin
            hi_d    = a_i;
            lo_d    = '1;
            state_d = StDone;
          end else begin
            state_d   = StBusy;
            cnt_d     = 5'd31;
            acc_hi_d  = '0;
            acc_lo_d  = a_mag;
            mag_b_d   = b_mag;
            is_div_d  = op_i[1];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      StBusy: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = StDone;
          if (is_div_q) begin
            lo_d = neg_res_q ? (32'd0 - step_lo) : step_lo;
            hi_d = neg_rem_q ? (32'd0 - step_hi) : step_hi;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mag_b_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      mag_b_q   <= mag_b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Start is ignored in StDone so the retiring instruction does not reissue.
  assign stall_o = reset_n & (((state_q == StIdle) & start_i & ~div_zero) |
                              (state_q == StBusy));
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU decode, branch resolution, control forwarding.
// Define EX_MULDIV_EN to include the iterative multiply/divide unit with HI/LO and stall_out.
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        RegDst_in,
  input  logic        ALUSrc_in,
  input  logic        Branch_in,
  input  logic [1:0]  ALUOp_in,
  input  logic [31:0] pc_next_in,
  input  logic [31:0] read_data1_in,
  input  logic [31:0] read_data2_in,
  input  logic [31:0] sign_ext_in,
  input  logic [4:0]  rs_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic [5:0]  opcode_in,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        MemRead_out,
  output logic        MemWrite_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] write_data_out,
  output logic [4:0]  write_reg_out,
  output logic [31:0] branch_target_out,
  output logic        branch_taken_out,
  output logic        stall_out
);

  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] op_a, op_b, imm_zext, hi_val, lo_val, alu_r;
  logic        is_muldiv;

  assign funct     = sign_ext_in[5:0];
  assign shamt     = sign_ext_in[10:6];
  assign op_a      = read_data1_in;
  assign op_b      = ALUSrc_in ? sign_ext_in : read_data2_in;
  assign imm_zext  = {16'd0, sign_ext_in[15:0]};
  assign is_muldiv = (ALUOp_in == AluOpFunct) && is_muldiv_funct(funct);

`ifdef EX_MULDIV_EN
  muldiv_unit u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (is_muldiv),
    .op_i    (funct[1:0]),
    .a_i     (read_data1_in),
    .b_i     (read_data2_in),
    .hi_o    (hi_val),
    .lo_o    (lo_val),
    .stall_o (stall_out)
  );
  logic unused_rs;
  assign unused_rs = ^rs_in;
`else
  assign hi_val    = '0;
  assign lo_val    = '0;
  assign stall_out = 1'b0;
  logic unused_sigs;
  assign unused_sigs = ^{clk, reset_n, rs_in};
`endif

  always_comb begin
    alu_r = '0;
    unique case (ALUOp_in)
      AluOpAdd: alu_r = op_a + op_b;
      AluOpSub: alu_r = op_a - op_b;
      AluOpFunct: begin
        case (funct)
          FnAdd, FnAddu: alu_r = op_a + op_b;
          FnSub, FnSubu: alu_r = op_a - op_b;
          FnAnd:         alu_r = op_a & op_b;
          FnOr:          alu_r = op_a | op_b;
          FnXor:         alu_r = op_a ^ op_b;
          FnNor:         alu_r = ~(op_a | op_b);
          FnSlt:         alu_r = {31'd0, $signed(op_a) < $signed(op_b)};
          FnSltu:        alu_r = {31'd0, op_a < op_b};
          FnSll:         alu_r = op_b << shamt;
          FnSrl:         alu_r = op_b >> shamt;
          FnSra:         alu_r = $signed(op_b) >>> shamt;
          FnMfhi:        alu_r = hi_val;
          FnMflo:        alu_r = lo_val;
          default:       alu_r = '0;
        endcase
      end
      AluOpImm: begin
        case (opcode_in)
          OpAddi:  alu_r = op_a + op_b;
          OpAndi:  alu_r = op_a & imm_zext;
          OpOri:   alu_r = op_a | imm_zext;
          OpXori:  alu_r = op_a ^ imm_zext;
          OpSlti:  alu_r = {31'd0, $signed(op_a) < $signed(op_b)};
          OpLui:   alu_r = {sign_ext_in[15:0], 16'd0};
          default: alu_r = '0;
        endcase
      end
      default: alu_r = '0;
    endcase
  end

  assign alu_result_out    = alu_r;
  assign RegWrite_out      = RegWrite_in & ~is_muldiv;
  assign MemtoReg_out      = MemtoReg_in;
  assign MemRead_out       = MemRead_in;
  assign MemWrite_out      = MemWrite_in;
  assign write_data_out    = read_data2_in;
  assign write_reg_out     = RegDst_in ? rd_in : rt_in;
  assign branch_target_out = pc_next_in + {sign_ext_in[29:0], 2'b00};
  assign branch_taken_out  = Branch_in &
                             (((opcode_in == OpBeq) & (read_data1_in == read_data2_in)) |
                              ((opcode_in == OpBne) & (read_data1_in != read_data2_in)));

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: behavioural reference model plus directed vectors.
module tb_ex_stage;

`ifdef EX_MULDIV_EN
  localparam bit MdEn = 1'b1;
`else
  localparam bit MdEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
  logic        RegDst_in, ALUSrc_in, Branch_in;
  logic [1:0]  ALUOp_in;
  logic [31:0] pc_next_in, read_data1_in, read_data2_in, sign_ext_in;
  logic [4:0]  rs_in, rt_in, rd_in;
  logic [5:0]  opcode_in;
  logic        RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out;
  logic [31:0] alu_result_out, write_data_out, branch_target_out;
  logic [4:0]  write_reg_out;
  logic        branch_taken_out, stall_out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  ex_stage dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .RegWrite_in       (RegWrite_in),
    .MemtoReg_in       (MemtoReg_in),
    .MemRead_in        (MemRead_in),
    .MemWrite_in       (MemWrite_in),
    .RegDst_in         (RegDst_in),
    .ALUSrc_in         (ALUSrc_in),
    .Branch_in         (Branch_in),
    .ALUOp_in          (ALUOp_in),
    .pc_next_in        (pc_next_in),
    .read_data1_in     (read_data1_in),
    .read_data2_in     (read_data2_in),
    .sign_ext_in       (sign_ext_in),
    .rs_in             (rs_in),
    .rt_in             (rt_in),
    .rd_in             (rd_in),
    .opcode_in         (opcode_in),
    .RegWrite_out      (RegWrite_out),
    .MemtoReg_out      (MemtoReg_out),
    .MemRead_out       (MemRead_out),
    .MemWrite_out      (MemWrite_out),
    .alu_result_out    (alu_result_out),
    .write_data_out    (write_data_out),
    .write_reg_out     (write_reg_out),
    .branch_target_out (branch_target_out),
    .branch_taken_out  (branch_taken_out),
    .stall_out         (stall_out)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model state: HI/LO, cycles left until result lands, one-cycle done window.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;
  bit          m_done = 1'b0;

  function automatic logic md_now();
    return ALUOp_in == 2'b10 && sign_ext_in[5:0] >= 6'h18 && sign_ext_in[5:0] <= 6'h1B;
  endfunction

  function automatic logic [63:0] md_result(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f[1:0])
      2'd0:    r = sa * sb;
      2'd1:    r = {32'd0, a} * {32'd0, b};
      2'd2:    r = {32'(sa % sb), 32'(sa / sb)};
      default: r = {a % b, a / b};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] exp_alu();
    logic [31:0] a, b, iz;
    logic [4:0]  sh;
    a  = read_data1_in;
    b  = ALUSrc_in ? sign_ext_in : read_data2_in;
    iz = {16'd0, sign_ext_in[15:0]};
    sh = sign_ext_in[10:6];
    case (ALUOp_in)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b10:
        case (sign_ext_in[5:0])
          6'h20, 6'h21: return a + b;
          6'h22, 6'h23: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h26: return a ^ b;
          6'h27: return ~(a | b);
          6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: return (a < b) ? 32'd1 : 32'd0;
          6'h00: return b << sh;
          6'h02: return b >> sh;
          6'h03: return $signed(b) >>> sh;
          6'h10: return m_hi;
          6'h12: return m_lo;
          default: return 32'd0;
        endcase
      default:
        case (opcode_in)
          6'h08: return a + b;
          6'h0C: return a & iz;
          6'h0D: return a | iz;
          6'h0E: return a ^ iz;
          6'h0A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h0F: return {sign_ext_in[15:0], 16'd0};
          default: return 32'd0;
        endcase
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
      m_done <= 1'b0;
    end else if (MdEn) begin
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_done <= 1'b1;
        end
      end else if (m_done) begin
        m_done <= 1'b0;
      end else if (md_now()) begin
        if (sign_ext_in[1] && read_data2_in == 32'd0) begin
          m_hi   <= read_data1_in;
          m_lo   <= 32'hFFFF_FFFF;
          m_done <= 1'b1;
        end else begin
          {p_hi, p_lo} <= md_result(sign_ext_in[5:0], read_data1_in, read_data2_in);
          m_left       <= 32;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic exp_stall, exp_br;
      exp_stall = reset_n && MdEn && (m_left > 0 ||
                  (!m_done && md_now() && !(sign_ext_in[1] && read_data2_in == 32'd0)));
      exp_br = Branch_in && ((opcode_in == 6'h04 && read_data1_in == read_data2_in) ||
                             (opcode_in == 6'h05 && read_data1_in != read_data2_in));
      cmp("m_alu", alu_result_out, exp_alu());
      cmp("m_regwrite", {31'd0, RegWrite_out}, {31'd0, RegWrite_in && !md_now()});
      cmp("m_ctrl", {29'd0, MemtoReg_out, MemRead_out, MemWrite_out},
          {29'd0, MemtoReg_in, MemRead_in, MemWrite_in});
      cmp("m_wdata", write_data_out, read_data2_in);
      cmp("m_wreg", {27'd0, write_reg_out}, {27'd0, RegDst_in ? rd_in : rt_in});
      cmp("m_target", branch_target_out, pc_next_in + sign_ext_in * 4);
      cmp("m_taken", {31'd0, branch_taken_out}, {31'd0, exp_br});
      cmp("m_stall", {31'd0, stall_out}, {31'd0, exp_stall});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    ALUOp_in = 2'b10; ALUSrc_in = 1'b0; RegDst_in = 1'b1; RegWrite_in = 1'b1;
    Branch_in = 1'b0; opcode_in = 6'h00;
    read_data1_in = a; read_data2_in = b; sign_ext_in = {21'd0, sh, f};
  endtask

  task automatic set_i(input logic [5:0] op, input logic [31:0] a, input logic [31:0] imm);
    ALUOp_in = 2'b11; ALUSrc_in = 1'b1; RegDst_in = 1'b0; RegWrite_in = 1'b1;
    Branch_in = 1'b0; opcode_in = op;
    read_data1_in = a; read_data2_in = 32'h5555_AAAA; sign_ext_in = imm;
  endtask

  task automatic count_stall(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall_out) n++;
      else break;
    end
  endtask

  logic [5:0] fn_tab [12] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

  initial begin
    int n;
    RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
    RegDst_in = 0; ALUSrc_in = 0; Branch_in = 0; ALUOp_in = 2'b00;
    pc_next_in = 32'h0; read_data1_in = 0; read_data2_in = 0; sign_ext_in = 0;
    rs_in = 5'd1; rt_in = 5'd3; rd_in = 5'd9; opcode_in = 6'h00;
    cmp_en = 1'b1;
    @(negedge clk);
    cmp("reset_stall", {31'd0, stall_out}, 32'd0);
    tick(1);
    reset_n = 1'b1;

    // R-type sub
    set_r(6'h22, 32'd5, 32'd7, 5'd0);
    #1;
    cmp("sub_result", alu_result_out, 32'hFFFF_FFFE);
    cmp("sub_regwrite", {31'd0, RegWrite_out}, 32'd1);
    cmp("sub_wreg", {27'd0, write_reg_out}, 32'd9);
    tick(1);
    for (int i = 0; i < 12; i++) begin
      set_r(fn_tab[i], 32'hF0F0_1234, 32'h8000_0003, 5'd4);
      MemtoReg_in = i[0]; MemRead_in = i[1]; MemWrite_in = i[2];
      tick(1);
    end
    MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
    set_r(6'h24, 32'hF0F0_1234, 32'h8000_0003, 5'd4); #1;
    cmp("and_result", alu_result_out, 32'h8000_0000);
    set_r(6'h03, 32'h0, 32'h8000_0003, 5'd4); #1;
    cmp("sra_result", alu_result_out, 32'hF800_0000);
    set_r(6'h2B, 32'd1, 32'h8000_0000, 5'd0); #1;
    cmp("sltu_result", alu_result_out, 32'd1);
    set_r(6'h2A, 32'd1, 32'h8000_0000, 5'd0); #1;
    cmp("slt_result", alu_result_out, 32'd0);
    tick(1);

    // Immediate forms
    set_i(6'h0D, 32'h10, 32'hFFFF_8001); #1;
    cmp("ori_result", alu_result_out, 32'h0000_8011);
    cmp("ori_wreg", {27'd0, write_reg_out}, 32'd3);
    tick(1);
    set_i(6'h0F, 32'h0, 32'h0000_1234); #1;
    cmp("lui_result", alu_result_out, 32'h1234_0000);
    tick(1);
    set_i(6'h0A, 32'hFFFF_FFFF, 32'h0); #1;
    cmp("slti_result", alu_result_out, 32'd1);
    tick(1);
    set_i(6'h08, 32'd5, 32'hFFFF_FFFF); tick(1);
    set_i(6'h0E, 32'h0F0F_0F0F, 32'hFFFF_00FF); tick(1);
    set_i(6'h3F, 32'h1234, 32'h1); tick(1);

    // Branches
    ALUOp_in = 2'b01; ALUSrc_in = 0; RegWrite_in = 0; Branch_in = 1; opcode_in = 6'h04;
    read_data1_in = 32'h10; read_data2_in = 32'h10; sign_ext_in = 32'hFFFF_FFFF;
    pc_next_in = 32'h100; #1;
    cmp("beq_taken", {31'd0, branch_taken_out}, 32'd1);
    cmp("beq_target", branch_target_out, 32'h0000_00FC);
    tick(1);
    opcode_in = 6'h05; #1;
    cmp("bne_eq_taken", {31'd0, branch_taken_out}, 32'd0);
    tick(1);
    read_data2_in = 32'h11; tick(1);
    opcode_in = 6'h04; tick(1);
    Branch_in = 0; read_data2_in = 32'h10; #1;
    cmp("beq_gated", {31'd0, branch_taken_out}, 32'd0);
    tick(1);

    if (MdEn) begin
      set_r(6'h18, 32'hFFFF_FFFE, 32'd3, 5'd0); #1;
      cmp("mult_regwrite", {31'd0, RegWrite_out}, 32'd0);
      cmp("mult_result", alu_result_out, 32'd0);
      count_stall(n);
      cmp("mult_stall_cycles", n, 32'd33);
      tick(1);
      set_r(6'h12, 0, 0, 0); #1;
      cmp("mult_lo", alu_result_out, 32'hFFFF_FFFA);
      tick(1);
      set_r(6'h10, 0, 0, 0); #1;
      cmp("mult_hi", alu_result_out, 32'hFFFF_FFFF);
      tick(1);

      set_r(6'h1A, 32'hFFFF_FFF9, 32'd2, 5'd0);
      count_stall(n);
      cmp("div_stall_cycles", n, 32'd33);
      tick(1);
      set_r(6'h12, 0, 0, 0); #1;
      cmp("div_lo", alu_result_out, 32'hFFFF_FFFD);
      tick(1);
      set_r(6'h10, 0, 0, 0); #1;
      cmp("div_hi", alu_result_out, 32'hFFFF_FFFF);
      tick(1);

      set_r(6'h1B, 32'd7, 32'd0, 5'd0); #1;
      cmp("div0_stall", {31'd0, stall_out}, 32'd0);
      tick(1);
      set_r(6'h12, 0, 0, 0); #1;
      cmp("div0_lo", alu_result_out, 32'hFFFF_FFFF);
      tick(1);
      set_r(6'h10, 0, 0, 0); #1;
      cmp("div0_hi", alu_result_out, 32'd7);
      tick(1);

      // Reset during BUSY
      set_r(6'h18, 32'd5, 32'd6, 5'd0);
      repeat (10) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      cmp("rst_stall", {31'd0, stall_out}, 32'd0);
      set_r(6'h12, 0, 0, 0);
      tick(2);
      reset_n = 1'b1; #1;
      cmp("rst_lo", alu_result_out, 32'd0);
      tick(1);
      set_r(6'h10, 0, 0, 0); #1;
      cmp("rst_hi", alu_result_out, 32'd0);
      tick(1);

      // Back-to-back multu
      set_r(6'h19, 32'hFFFF_FFFF, 32'd2, 5'd0);
      count_stall(n);
      cmp("multu1_stall_cycles", n, 32'd33);
      tick(1);
      set_r(6'h19, 32'd3, 32'd5, 5'd0);
      count_stall(n);
      cmp("multu2_stall_cycles", n, 32'd33);
      tick(1);
      set_r(6'h12, 0, 0, 0); #1;
      cmp("multu2_lo", alu_result_out, 32'd15);
      tick(1);
      set_r(6'h10, 0, 0, 0); #1;
      cmp("multu2_hi", alu_result_out, 32'd0);
      tick(1);
      set_r(6'h19, 32'hFFFF_FFFF, 32'd2, 5'd0);
      count_stall(n);
      tick(1);
      set_r(6'h10, 0, 0, 0); #1;
      cmp("multu3_hi", alu_result_out, 32'd1);
      tick(1);
      set_r(6'h12, 0, 0, 0); #1;
      cmp("multu3_lo", alu_result_out, 32'hFFFF_FFFE);
      tick(1);
    end else begin
      set_r(6'h18, 32'hFFFF_FFFE, 32'd3, 5'd0); #1;
      cmp("nomd_regwrite", {31'd0, RegWrite_out}, 32'd0);
      cmp("nomd_result", alu_result_out, 32'd0);
      cmp("nomd_stall", {31'd0, stall_out}, 32'd0);
      tick(2);
      set_r(6'h1A, 32'd7, 32'd0, 5'd0); tick(2);
      set_r(6'h12, 0, 0, 0); #1;
      cmp("nomd_mflo", alu_result_out, 32'd0);
      tick(1);
      set_r(6'h10, 0, 0, 0); #1;
      cmp("nomd_mfhi", alu_result_out, 32'd0);
      tick(1);
    end

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
